// File: rtl/toggle_arb_pkg.sv
// Shared types and the round-robin pick helper for the toggle burst arbiter.
package toggle_arb_pkg;

  typedef enum logic [1:0] {StIdle, StGrant, StRun, StDone} state_e;

  localparam int unsigned MaxReq = 16;
  localparam int unsigned IdxW   = 4;

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
  } rr_pick_t;

  // First set request searching upward from ptr+1, wrapping modulo n_req.
  function automatic rr_pick_t rr_pick(input logic [MaxReq-1:0] req,
                                       input logic [IdxW-1:0]   ptr,
                                       input int unsigned       n_req);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 1; i <= MaxReq; i++) begin
      cand = {28'd0, ptr} + i;
      if (cand >= n_req) cand = cand - n_req;
      if (i <= n_req && !res.valid && req[cand[IdxW-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = cand[IdxW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/toggle_cell.sv
// Single toggling output flop shared by all requesters.
module toggle_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else if (en) begin
      out <= ~out;
    end
  end

endmodule

// File: rtl/toggle_burst_arbiter.sv
// Round-robin arbiter granting the shared toggle generator for length-L bursts.
module toggle_burst_arbiter
  import toggle_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LEN_W-1:0]   len,
  input  logic                     abort,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     aborted,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] active_id,
  output logic                     toggle_out
);

  localparam int unsigned IdW = $clog2(N_REQ);

  state_e           state_q;
  logic [IdW-1:0]   ptr_q;
  logic [IdW-1:0]   active_id_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [N_REQ-1:0] gnt_q;
  logic [N_REQ-1:0] done_q;
  logic             aborted_q;
  logic             busy_q;

  logic [MaxReq-1:0] req_ext;
  logic [IdxW-1:0]   ptr_ext;
  rr_pick_t          pick;
  logic [IdW-1:0]    pick_id;
  logic              run_en;
  logic              unused_pick;

  always_comb begin
    req_ext            = '0;
    req_ext[N_REQ-1:0] = req;
    ptr_ext            = '0;
    ptr_ext[IdW-1:0]   = ptr_q;
    pick               = rr_pick(req_ext, ptr_ext, N_REQ);
    pick_id            = pick.idx[IdW-1:0];
  end

  assign unused_pick = ^pick;

  // Abort suppresses the toggle on the very edge it is seen.
  assign run_en = (state_q == StRun) && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= IdW'(N_REQ - 1);
      active_id_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q    <= '0;
      aborted_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick.valid) begin
            state_q          <= StGrant;
            gnt_q            <= '0;
            gnt_q[pick_id]   <= 1'b1;
            active_id_q      <= pick_id;
            ptr_q            <= pick_id;
            len_q            <= len[int'(pick_id) * LEN_W +: LEN_W];
            busy_q           <= 1'b1;
          end
        end
        StGrant: begin
          if (len_q == '0) begin
            state_q <= StDone;
            gnt_q   <= '0;
            done_q  <= gnt_q;
          end else begin
            state_q <= StRun;
            cnt_q   <= len_q;
          end
        end
        StRun: begin
          if (abort) begin
            state_q   <= StDone;
            gnt_q     <= '0;
            done_q    <= gnt_q;
            aborted_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q <= StDone;
              gnt_q   <= '0;
              done_q  <= gnt_q;
            end
          end
        end
        StDone: begin
          state_q     <= StIdle;
          active_id_q <= '0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  toggle_cell u_toggle_cell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .out   (toggle_out)
  );

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign busy      = busy_q;
  assign active_id = active_id_q;

endmodule

// File: tb/tb_toggle_burst_arbiter.sv
// Directed bench for toggle_burst_arbiter: burst table plus fairness and reset sequences.
module tb_toggle_burst_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic           abort;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           aborted;
  logic           busy;
  logic [1:0]     active_id;
  logic           toggle_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic tog_model;

  toggle_burst_arbiter #(.N_REQ(N), .LEN_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .len        (len),
    .abort      (abort),
    .gnt        (gnt),
    .done       (done),
    .aborted    (aborted),
    .busy       (busy),
    .active_id  (active_id),
    .toggle_out (toggle_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] lens;      // {len3, len2, len1, len0}
    int          abort_run; // RUN edge index carrying abort, 0 = none
    int          exp_id;
    int          exp_tog;
    logic        exp_ab;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tog_model = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int         c;
    int         tog;
    int         l;
    int         exp_c;
    logic       prev;
    logic       seen;
    logic [3:0] oh;
    l  = int'(v.lens[v.exp_id*8 +: 8]);
    oh = 4'b0001 << v.exp_id;
    if (v.exp_ab) exp_c = 1 + v.abort_run;
    else if (l == 0) exp_c = 1;
    else exp_c = 1 + l;

    @(negedge clk);
    req   = v.req;
    len   = v.lens;
    abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("grant", gnt, oh);
    check("active_id", active_id, v.exp_id);
    check("busy_on_grant", busy, 1);
    req  = '0;
    len  = ~v.lens;
    prev = toggle_out;
    tog  = 0;
    seen = 1'b0;
    c    = 0;
    while (!seen && c < 300) begin
      c++;
      abort = (v.abort_run != 0) && (c == 1 + v.abort_run);
      @(posedge clk);
      @(negedge clk);
      if (toggle_out !== prev) tog++;
      prev = toggle_out;
      if (done != '0) seen = 1'b1;
    end
    abort = 1'b0;
    check("done_seen", seen, 1);
    check("done_latency", c, exp_c);
    check("done_onehot", done, oh);
    check("aborted", aborted, v.exp_ab);
    check("gnt_low_at_done", gnt, 0);
    check("toggle_count", tog, v.exp_tog);
    tog_model = tog_model ^ v.exp_tog[0];
    check("toggle_level", toggle_out, tog_model);
    @(posedge clk);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("aborted_cleared", aborted, 0);
    check("busy_cleared", busy, 0);
    check("active_id_idle", active_id, 0);
  endtask

  initial begin
    int         ids[5];
    int         cycs[5];
    int         k;
    int         cyc;

    vecs[0] = '{req: 4'b0001, lens: {8'd0, 8'd0, 8'd0, 8'd3},  abort_run: 0, exp_id: 0, exp_tog: 3,   exp_ab: 1'b0};
    vecs[1] = '{req: 4'b0100, lens: {8'd9, 8'd0, 8'd9, 8'd9},  abort_run: 0, exp_id: 2, exp_tog: 0,   exp_ab: 1'b0};
    vecs[2] = '{req: 4'b0001, lens: {8'd0, 8'd0, 8'd0, 8'd10}, abort_run: 4, exp_id: 0, exp_tog: 3,   exp_ab: 1'b1};
    vecs[3] = '{req: 4'b0001, lens: {8'd0, 8'd0, 8'd0, 8'd2},  abort_run: 2, exp_id: 0, exp_tog: 1,   exp_ab: 1'b1};
    vecs[4] = '{req: 4'b0010, lens: {8'd0, 8'd0, 8'd5, 8'd0},  abort_run: 0, exp_id: 1, exp_tog: 5,   exp_ab: 1'b0};
    vecs[5] = '{req: 4'b1010, lens: {8'd4, 8'd0, 8'd1, 8'd0},  abort_run: 0, exp_id: 3, exp_tog: 4,   exp_ab: 1'b0};
    vecs[6] = '{req: 4'b1010, lens: {8'd4, 8'd0, 8'd1, 8'd0},  abort_run: 0, exp_id: 1, exp_tog: 1,   exp_ab: 1'b0};
    vecs[7] = '{req: 4'b1000, lens: {8'd255, 8'd0, 8'd0, 8'd0}, abort_run: 0, exp_id: 3, exp_tog: 255, exp_ab: 1'b0};

    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    abort = 1'b0;
    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_busy", busy, 0);
    check("rst_active_id", active_id, 0);
    check("rst_toggle", toggle_out, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Fairness: all requesters held, each burst length 2.
    do_reset();
    req = 4'b1111;
    len = 32'h0202_0202;
    k   = 0;
    cyc = 0;
    while (k < 5 && cyc < 100) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        ids[k] = -1;
        for (int b = 0; b < N; b++) if (done[b]) ids[k] = b;
        cycs[k] = cyc;
        k++;
        if (k == 5) req = '0;
      end
    end
    check("fair_done_count", k, 5);
    for (int j = 0; j < k; j++) begin
      check("fair_order", ids[j], j % 4);
      if (j > 0) check("fair_spacing", cycs[j] - cycs[j-1], 5);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("fair_idle", busy, 0);
    check("fair_toggle_level", toggle_out, tog_model);

    // Mid-burst reset, with abort held through IDLE and GRANT edges.
    do_reset();
    req   = 4'b0010;
    len   = {8'd0, 8'd0, 8'd5, 8'd0};
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mr_grant", gnt, 4'b0010);
    req = '0;
    @(posedge clk);
    @(negedge clk);
    check("mr_abort_ignored_busy", busy, 1);
    check("mr_abort_ignored_done", done, 0);
    check("mr_no_toggle_in_grant", toggle_out, 0);
    abort = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mr_run1_toggle", toggle_out, 1);
    @(posedge clk);
    @(negedge clk);
    check("mr_run2_toggle", toggle_out, 0);
    check("mr_no_done_yet", done, 0);
    @(posedge clk);
    @(negedge clk);
    check("mr_run3_toggle", toggle_out, 1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mr_rst_gnt", gnt, 0);
    check("mr_rst_done", done, 0);
    check("mr_rst_busy", busy, 0);
    check("mr_rst_aborted", aborted, 0);
    check("mr_rst_active_id", active_id, 0);
    check("mr_rst_toggle", toggle_out, 0);
    rst_n = 1'b1;
    req   = 4'b0011;
    len   = {8'd0, 8'd0, 8'd3, 8'd1};
    @(posedge clk);
    @(negedge clk);
    check("mr_regrant_req0", gnt, 4'b0001);
    check("mr_regrant_id", active_id, 0);
    check("mr_no_stale_done", done, 0);
    req = '0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
